// File: rtl/ibert_stream_pkg.sv
// Shared types for the stream-processing blocks.
package ibert_stream_pkg;

  typedef enum logic [1:0] {
    ARESET = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2
  } accum_state_t;

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle: data, valid/ready handshake and end-of-packet marker.
interface axi_stream_if #(
  parameter int unsigned D_W = 8
);
  logic [D_W-1:0] tdata;
  logic           tvalid;
  logic           tready;
  logic           tlast;

  modport axi_in  (input  tdata, input  tvalid, input  tlast, output tready);
  modport axi_out (output tdata, output tvalid, output tlast, input  tready);
endinterface

// File: rtl/accum_ram.sv
// Accumulator storage: one synchronous write port, independent asynchronous read port.
module accum_ram #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_vector_accum.sv
// Column-wise reducer: folds a DIM1 x DIM2 row-major matrix stream into one DIM2-element
// vector of signed column sums, then streams that vector out with tlast on its final element.
module stream_vector_accum
  import ibert_stream_pkg::*;
#(
  parameter int unsigned D_W          = 8,
  parameter int unsigned ACC_W        = 32,
  parameter int unsigned MATRIXSIZE_W = 24,
  parameter int unsigned MEM_DEPTH    = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_stream_if.axi_in            in_mat,
  axi_stream_if.axi_out           out_vec,
  input  logic [MATRIXSIZE_W-1:0] DIM1,
  input  logic [MATRIXSIZE_W-1:0] DIM2,
  output logic                    len_err
);

  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

  accum_state_t state_q, state_d;

  logic [ADDR_W-1:0]       col_q, col_d;
  logic [ADDR_W-1:0]       rdaddr_q, rdaddr_d;
  logic [MATRIXSIZE_W-1:0] row_q, row_d;
  logic                    len_err_q, len_err_d;

  logic [MATRIXSIZE_W-1:0] dim1_last, dim2_last;
  logic                    col_last, row_last, rd_last, term_elem;
  logic                    in_hs, out_hs;

  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_raddr;
  logic [ACC_W-1:0]        ram_rdata, ram_wdata, elem_ext;

  assign dim1_last = DIM1 - MATRIXSIZE_W'(1);
  assign dim2_last = DIM2 - MATRIXSIZE_W'(1);

  assign col_last  = (MATRIXSIZE_W'(col_q) == dim2_last);
  assign row_last  = (row_q == dim1_last);
  assign rd_last   = (MATRIXSIZE_W'(rdaddr_q) == dim2_last);
  assign term_elem = col_last & row_last;

  assign in_hs  = in_mat.tvalid & (state_q == ACCUM);
  assign out_hs = out_vec.tready & (state_q == DRAIN);

  assign elem_ext  = {{(ACC_W - D_W){in_mat.tdata[D_W-1]}}, in_mat.tdata[D_W-1:0]};
  // Row 0 overwrites the entry, so stale contents from earlier frames never leak in.
  assign ram_wdata = (row_q == '0) ? elem_ext : (ram_rdata + elem_ext);
  assign ram_raddr = (state_q == DRAIN) ? rdaddr_q : col_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    rdaddr_d  = rdaddr_q;
    len_err_d = 1'b0;
    ram_we    = 1'b0;

    unique case (state_q)
      ARESET: begin
        state_d = ACCUM;
      end

      ACCUM: begin
        if (in_hs) begin
          // Reset wins over a coincident handshake: no write, no counter movement.
          ram_we    = ~rst;
          len_err_d = (in_mat.tlast != term_elem);
          if (col_last) begin
            col_d = '0;
            if (row_last) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + MATRIXSIZE_W'(1);
            end
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
        end
      end

      DRAIN: begin
        if (out_hs) begin
          if (rd_last) begin
            rdaddr_d = '0;
            state_d  = ACCUM;
          end else begin
            rdaddr_d = rdaddr_q + ADDR_W'(1);
          end
        end
      end

      default: begin
        state_d = ARESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARESET;
      col_q     <= '0;
      row_q     <= '0;
      rdaddr_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      rdaddr_q  <= rdaddr_d;
      len_err_q <= len_err_d;
    end
  end

  accum_ram #(
    .WIDTH  (ACC_W),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_accum_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (col_q),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign in_mat.tready  = (state_q == ACCUM);
  assign out_vec.tvalid = (state_q == DRAIN);
  assign out_vec.tlast  = (state_q == DRAIN) & rd_last;
  assign out_vec.tdata  = ram_rdata;
  assign len_err        = len_err_q;

endmodule
